// File: rtl/rf_stack_pkg.sv
// Shared state encoding, default geometry and parity helper for the spill/fill stack.
// The parity helper is only referenced when RF_STACK_PARITY_EN is defined.
package rf_stack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPILL_B = 2'd1,
        FILL_B  = 2'd2
    } stack_state_e;

    localparam int DWIDTH_DEF    = 64;
    localparam int WIN_WORDS_DEF = 16;
    localparam int DEPTH_WIN_DEF = 4;

    localparam int WORDS_DEF  = DEPTH_WIN_DEF * WIN_WORDS_DEF;
    localparam int ADDR_W_DEF = $clog2(WORDS_DEF);
    localparam int K_W_DEF    = $clog2(WIN_WORDS_DEF);
    localparam int CNT_W_DEF  = $clog2(DEPTH_WIN_DEF + 1);

    // Wide enough for any practical DWIDTH; zero-extension leaves parity unchanged.
    localparam int PAR_MAX_W = 1024;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rf_stack_ram.sv
// Single-port synchronous RAM backing the spill/fill stack, with a registered read port.
module rf_stack_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // No reset on contents: a reset empties the stack by count only.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rf_spill_fill_stack.sv
// Window-granular LIFO backing store for the windowed register file (spill pushes, fill pops).
// Optional per-word even parity with sticky PERR output when RF_STACK_PARITY_EN is defined.
module rf_spill_fill_stack
    import rf_stack_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int WIN_WORDS = WIN_WORDS_DEF,
    parameter int DEPTH_WIN = DEPTH_WIN_DEF
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             SPILL,
    input  logic                             FILL,
    input  logic [DWIDTH-1:0]                MEM_BUS,
    output logic [DWIDTH-1:0]                MEM_BUSread,
    output logic                             MEM_VALID,
    output logic                             DONE,
    output logic                             BUSY,
    output logic [$clog2(DEPTH_WIN+1)-1:0]   WIN_CNT,
    output logic                             EMPTY,
    output logic                             FULL,
    output logic                             OVF,
    output logic                             UNF,
    output logic                             ABRT,
`ifdef RF_STACK_PARITY_EN
    output logic                             PERR,
`endif
    output logic [1:0]                       state_dbg_o
);

    localparam int WORDS  = DEPTH_WIN * WIN_WORDS;
    localparam int ADDR_W = $clog2(WORDS);
    localparam int K_W    = $clog2(WIN_WORDS);
    localparam int CNT_W  = $clog2(DEPTH_WIN + 1);
`ifdef RF_STACK_PARITY_EN
    localparam int RAM_W  = DWIDTH + 1;
`else
    localparam int RAM_W  = DWIDTH;
`endif
    localparam logic [K_W-1:0]   K_LAST  = K_W'(WIN_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH_WIN);

    stack_state_e     state_q;
    logic [K_W-1:0]   k_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic             nop_q;
    logic             done_q;
    logic             valid_q;
    logic             ovf_q;
    logic             unf_q;
    logic             abrt_q;

    logic              empty;
    logic              full;
    logic              ram_we;
    logic              ram_re;
    logic [CNT_W-1:0]  win_idx;
    logic [ADDR_W-1:0] ram_addr;
    logic [RAM_W-1:0]  ram_wdata;
    logic [RAM_W-1:0]  ram_rdata;

    assign empty = (win_cnt_q == '0);
    assign full  = (win_cnt_q == CNT_MAX);

    // Handshake: SPILL/FILL are level requests sampled every clock, one word per cycle and
    // no backpressure; MEM_VALID qualifies MEM_BUSread for one cycle per issued read.
    always_comb begin
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        win_idx = win_cnt_q;
        case (state_q)
            IDLE: begin
                if (SPILL) begin
                    ram_we = !full;
                end else if (FILL) begin
                    ram_re  = !empty;
                    win_idx = win_cnt_q - CNT_W'(1);
                end
            end
            SPILL_B: ram_we = SPILL && !nop_q;
            FILL_B: begin
                ram_re  = FILL && !nop_q;
                win_idx = win_cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign ram_addr = ADDR_W'(win_idx) * ADDR_W'(WIN_WORDS) + ADDR_W'(k_q);

`ifdef RF_STACK_PARITY_EN
    assign ram_wdata = {even_parity(PAR_MAX_W'(MEM_BUS)), MEM_BUS};
`else
    assign ram_wdata = MEM_BUS;
`endif

    rf_stack_ram #(
        .W     (RAM_W),
        .DEPTH (WORDS),
        .AW    (ADDR_W)
    ) u_ram (
        .clk_i   (CLK),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    // nop_q marks an overflow/underflow burst: it runs its full length but touches no storage.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            k_q       <= '0;
            win_cnt_q <= '0;
            nop_q     <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            abrt_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= ram_re;
            case (state_q)
                IDLE: begin
                    if (SPILL) begin
                        state_q <= SPILL_B;
                        k_q     <= K_W'(1);
                        nop_q   <= full;
                        if (full) begin
                            ovf_q <= 1'b1;
                        end
                    end else if (FILL) begin
                        state_q <= FILL_B;
                        k_q     <= K_W'(1);
                        nop_q   <= empty;
                        if (empty) begin
                            unf_q <= 1'b1;
                        end
                    end
                end
                SPILL_B: begin
                    if (!SPILL) begin
                        abrt_q  <= 1'b1;
                        state_q <= IDLE;
                        k_q     <= '0;
                    end else if (k_q == K_LAST) begin
                        state_q <= IDLE;
                        k_q     <= '0;
                        done_q  <= 1'b1;
                        if (!nop_q && !full) begin
                            win_cnt_q <= win_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                FILL_B: begin
                    if (!FILL) begin
                        abrt_q  <= 1'b1;
                        state_q <= IDLE;
                        k_q     <= '0;
                    end else if (k_q == K_LAST) begin
                        state_q <= IDLE;
                        k_q     <= '0;
                        done_q  <= 1'b1;
                        if (!nop_q && !empty) begin
                            win_cnt_q <= win_cnt_q - CNT_W'(1);
                        end
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RF_STACK_PARITY_EN
    logic perr_q;
    logic perr_now;

    // Stored word plus its parity bit must XOR to zero; flag in the cycle the word is delivered.
    assign perr_now = valid_q && (^ram_rdata);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perr_q <= 1'b0;
        end else if (perr_now) begin
            perr_q <= 1'b1;
        end
    end

    assign PERR = perr_q || perr_now;
`endif

    assign MEM_BUSread = valid_q ? ram_rdata[DWIDTH-1:0] : '0;
    assign MEM_VALID   = valid_q;
    assign DONE        = done_q;
    assign BUSY        = (state_q != IDLE);
    assign WIN_CNT     = win_cnt_q;
    assign EMPTY       = empty;
    assign FULL        = full;
    assign OVF         = ovf_q;
    assign UNF         = unf_q;
    assign ABRT        = abrt_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rf_spill_fill_stack.sv
// Bench for rf_spill_fill_stack: directed scenarios plus a random spill/fill/abort mix
// against a word-queue stack model. Define RF_STACK_PARITY_EN to add the parity scenario.
`timescale 1ns/1ps
module tb_rf_spill_fill_stack;
    import rf_stack_pkg::*;

    localparam int DW    = 64;
    localparam int WW    = 16;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          SPILL;
    logic          FILL;
    logic [DW-1:0] MEM_BUS;
    logic [DW-1:0] MEM_BUSread;
    logic          MEM_VALID;
    logic          DONE;
    logic          BUSY;
    logic [2:0]    WIN_CNT;
    logic          EMPTY;
    logic          FULL;
    logic          OVF;
    logic          UNF;
    logic          ABRT;
    logic [1:0]    state_dbg;
`ifdef RF_STACK_PARITY_EN
    logic          PERR;
    bit            exp_perr;
    int            bad_word = -1;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;
    int fail_cnt  = 0;

    // Model: every stored word, oldest window first; a window is WW consecutive entries.
    logic [DW-1:0] stk_q[$];
    logic [DW-1:0] exp_q[$];
    bit exp_ovf;
    bit exp_unf;
    bit exp_abrt;

    always #5 CLK = ~CLK;

    rf_spill_fill_stack u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SPILL       (SPILL),
        .FILL        (FILL),
        .MEM_BUS     (MEM_BUS),
        .MEM_BUSread (MEM_BUSread),
        .MEM_VALID   (MEM_VALID),
        .DONE        (DONE),
        .BUSY        (BUSY),
        .WIN_CNT     (WIN_CNT),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .OVF         (OVF),
        .UNF         (UNF),
        .ABRT        (ABRT),
`ifdef RF_STACK_PARITY_EN
        .PERR        (PERR),
`endif
        .state_dbg_o (state_dbg)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_status(input string tag);
        int n;
        n = stk_q.size() / WW;
        check({tag, ".win_cnt"}, WIN_CNT, n);
        check({tag, ".empty"}, EMPTY, n == 0);
        check({tag, ".full"}, FULL, n == DEPTH);
        check({tag, ".ovf"}, OVF, exp_ovf);
        check({tag, ".unf"}, UNF, exp_unf);
        check({tag, ".abrt"}, ABRT, exp_abrt);
`ifdef RF_STACK_PARITY_EN
        check({tag, ".perr"}, PERR, exp_perr);
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".rdata"}, MEM_BUSread, 0);
        check({tag, ".valid"}, MEM_VALID, 0);
        check({tag, ".done"}, DONE, 0);
        check({tag, ".busy"}, BUSY, 0);
        check({tag, ".state"}, state_dbg, IDLE);
        check({tag, ".win_cnt"}, WIN_CNT, 0);
        check({tag, ".empty"}, EMPTY, 1);
        check({tag, ".full"}, FULL, 0);
        check({tag, ".ovf"}, OVF, 0);
        check({tag, ".unf"}, UNF, 0);
        check({tag, ".abrt"}, ABRT, 0);
`ifdef RF_STACK_PARITY_EN
        check({tag, ".perr"}, PERR, 0);
`endif
    endtask

    // Asserts RESET between clock edges and checks outputs before any edge arrives.
    task automatic do_reset(input string tag);
        #2;
        RESET = 1'b0;
        #1;
        check_reset(tag);
        stk_q.delete();
        exp_ovf  = 0;
        exp_unf  = 0;
        exp_abrt = 0;
`ifdef RF_STACK_PARITY_EN
        exp_perr = 0;
`endif
        SPILL = 1'b0;
        FILL  = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        SPILL = 1'b0;
        FILL  = 1'b0;
        repeat (n) begin
            tick();
            check("idle.done", DONE, 0);
            check("idle.valid", MEM_VALID, 0);
            check("idle.state", state_dbg, IDLE);
        end
    endtask

    // nw < WW drops SPILL early (abort); rnd selects random data, else base+i.
    task automatic do_spill(input int nw, input bit fill_too, input bit rnd, input logic [DW-1:0] base);
        logic [DW-1:0] words[$];
        logic [DW-1:0] d;
        bit was_full;
        was_full = (stk_q.size() / WW == DEPTH);
        for (int i = 0; i < nw; i++) begin
            d = rnd ? {$urandom, $urandom} : base + DW'(i);
            words.push_back(d);
            SPILL   = 1'b1;
            FILL    = fill_too;
            MEM_BUS = d;
            tick();
            check("spill.state", state_dbg, (i < WW - 1) ? SPILL_B : IDLE);
            check("spill.done", DONE, i == WW - 1);
            check("spill.valid", MEM_VALID, 0);
        end
        SPILL = 1'b0;
        FILL  = 1'b0;
        if (was_full) exp_ovf = 1;
        if (nw == WW) begin
            if (!was_full) begin
                foreach (words[j]) stk_q.push_back(words[j]);
            end
            check_status("spill.end");
        end else begin
            tick();
            exp_abrt = 1;
            check("spill_abort.done", DONE, 0);
            check("spill_abort.state", state_dbg, IDLE);
            check_status("spill_abort");
        end
    endtask

    // nw < WW drops FILL early (abort); expected words are the newest window in spill order.
    task automatic do_fill(input int nw);
        logic [DW-1:0] e;
        bit was_empty;
        was_empty = (stk_q.size() == 0);
        exp_q.delete();
        if (!was_empty) begin
            for (int j = 0; j < WW; j++) exp_q.push_back(stk_q[stk_q.size() - WW + j]);
        end
        for (int i = 0; i < nw; i++) begin
            FILL  = 1'b1;
            SPILL = 1'b0;
            tick();
            check("fill.state", state_dbg, (i < WW - 1) ? FILL_B : IDLE);
            check("fill.done", DONE, i == WW - 1);
            if (was_empty) begin
                check("fill.valid", MEM_VALID, 0);
                check("fill.data", MEM_BUSread, 0);
            end else begin
                e = exp_q.pop_front();
                check("fill.valid", MEM_VALID, 1);
                check("fill.data", MEM_BUSread, e);
            end
`ifdef RF_STACK_PARITY_EN
            if (!was_empty && i == bad_word) exp_perr = 1;
            check("fill.perr", PERR, exp_perr);
`endif
        end
        FILL = 1'b0;
        if (was_empty) exp_unf = 1;
        if (nw == WW) begin
            if (!was_empty) begin
                repeat (WW) void'(stk_q.pop_back());
            end
            check_status("fill.end");
        end else begin
            tick();
            exp_abrt = 1;
            check("fill_abort.done", DONE, 0);
            check("fill_abort.valid", MEM_VALID, 0);
            check("fill_abort.state", state_dbg, IDLE);
            check_status("fill_abort");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET    = 1'b0;
        SPILL    = 1'b0;
        FILL     = 1'b0;
        MEM_BUS  = '0;
        exp_ovf  = 0;
        exp_unf  = 0;
        exp_abrt = 0;
`ifdef RF_STACK_PARITY_EN
        exp_perr = 0;
`endif
        #12;
        check_reset("reset.init");
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Single window round trip, 0x100..0x10F.
        do_spill(WW, 0, 0, 64'h100);
        idle(1);
        do_fill(WW);
        idle(2);

        // LIFO across two windows, spilled back to back.
        do_spill(WW, 0, 0, 64'hA0);
        do_spill(WW, 0, 0, 64'hB0);
        idle(1);
        do_fill(WW);
        do_fill(WW);
        idle(1);

        // Underflow from empty, then simultaneous requests resolve to a spill.
        do_fill(WW);
        idle(1);
        do_spill(WW, 1, 1, '0);
        idle(1);
        do_fill(WW);
        idle(1);

        // Spill dropped after 7 words.
        do_spill(7, 0, 1, '0);
        idle(1);

        // Overflow: five spills into a four-window stack.
        do_reset("reset.pre_ovf");
        repeat (5) do_spill(WW, 0, 1, '0);
        idle(1);
        do_fill(WW);
        idle(1);

        // Random mix of bursts, aborts and gaps.
        for (int op = 0; op < 40; op++) begin
            case ($urandom_range(0, 4))
                0, 1: do_spill(WW, 1'($urandom_range(0, 1)), 1, '0);
                2, 3: do_fill(WW);
                default: begin
                    if ($urandom_range(0, 1) == 1) do_spill($urandom_range(1, WW - 1), 0, 1, '0);
                    else do_fill($urandom_range(1, WW - 1));
                end
            endcase
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        // Asynchronous reset in the middle of a fill burst.
        do_spill(WW, 0, 1, '0);
        idle(1);
        FILL = 1'b1;
        repeat (5) tick();
        do_reset("reset.mid_fill");
        do_fill(WW);
        idle(1);

`ifdef RF_STACK_PARITY_EN
        do_reset("reset.pre_parity");
        do_spill(WW, 0, 0, 64'h300);
        idle(1);
        u_dut.u_ram.mem_q[3] = u_dut.u_ram.mem_q[3] ^ 65'h20;
        stk_q[3] = stk_q[3] ^ 64'h20;
        bad_word = 3;
        do_fill(WW);
        bad_word = -1;
        idle(2);
        check_status("parity.after");
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
